eth_tx_frame_arbiter: RTL

//   Frame-granular round-robin arbiter that shares the single 64-bit AXI-Stream TX port
//   of the 10G Ethernet MAC among N_PORTS requesters.
//   - A grant is held from the first beat of a frame until its tlast handshake, so frames are never interleaved.
//   - A beat watchdog truncates runaway frames: it forces tlast with tuser=1 so the MAC aborts the frame,

---
 rtl/eth_tx_frame_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-granular round-robin arbiter with beat watchdog for the 10G MAC TX stream
module eth_tx_frame_arbiter #(
   parameter int N_PORTS   = 2,
   parameter int MAX_BEATS = 1200,
   parameter int CNT_W     = 32
) (
   input  logic                       clk156,
   input  logic                       reset,
   input  logic [N_PORTS*64-1:0]      s_axis_tdata,
   input  logic [N_PORTS*8-1:0]       s_axis_tkeep,
   input  logic [N_PORTS-1:0]         s_axis_tlast,
   input  logic [N_PORTS-1:0]         s_axis_tuser,
   input  logic [N_PORTS-1:0]         s_axis_tvalid,
   output logic [N_PORTS-1:0]         s_axis_tready,
   output logic [63:0]                m_axis_tx_tdata,
   output logic [7:0]                 m_axis_tx_tkeep,
   output logic                       m_axis_tx_tlast,
   output logic                       m_axis_tx_tuser,
   output logic                       m_axis_tx_tvalid,
   input  logic                       m_axis_tx_tready,
   output logic [$clog2(N_PORTS)-1:0] grant_idx,
   output logic                       busy,
   output logic [CNT_W-1:0]           frames_sent,
   output logic [CNT_W-1:0]           frames_aborted
);
   localparam int GW = $clog2(N_PORTS);
   localparam int BW = $clog2(MAX_BEATS + 1);
   typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;
   state_t state, state_nxt;
   logic [GW-1:0] next_idx;
   logic [BW-1:0] beat_cnt;
   logic [63:0] sel_data;
   logic [7:0] sel_keep;
   logic sel_last, sel_user, sel_valid, beat, abort;
   int best_d, d;
   always_comb begin
      next_idx = grant_idx;
      best_d = N_PORTS;
      sel_data = '0;
      sel_keep = '0;
      sel_last = 1'b0;
      sel_user = 1'b0;
      sel_valid = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         d = (i - int'(grant_idx) - 1 + 2 * N_PORTS) % N_PORTS;
         if (s_axis_tvalid[i] && d < best_d) begin
            best_d = d;
            next_idx = GW'(i);
         end
         if (GW'(i) == grant_idx) begin
            sel_data = s_axis_tdata[i*64 +: 64];
            sel_keep = s_axis_tkeep[i*8 +: 8];
            sel_last = s_axis_tlast[i];
            sel_user = s_axis_tuser[i];
            sel_valid = s_axis_tvalid[i];
         end
      end
   end
   // the watchdog fires on the MAX_BEATS-th accepted beat unless the source closes the frame there itself
   assign beat = state == PASS && sel_valid && m_axis_tx_tready;
   assign abort = beat && !sel_last && beat_cnt == BW'(MAX_BEATS - 1);
   assign m_axis_tx_tdata = sel_data;
   assign m_axis_tx_tkeep = sel_keep;
   assign m_axis_tx_tlast = sel_last | abort;
   assign m_axis_tx_tuser = sel_user | abort;
   assign m_axis_tx_tvalid = !reset && state == PASS && sel_valid;
   assign busy = state != IDLE;
   always_comb begin
      s_axis_tready = '0;
      for (int i = 0; i < N_PORTS; i++)
         s_axis_tready[i] = !reset && GW'(i) == grant_idx && (state == PASS ? m_axis_tx_tready : state == DRAIN);
      state_nxt = state == IDLE ? (|s_axis_tvalid ? PASS : IDLE)
                : state == PASS ? (beat && sel_last ? IDLE : abort ? DRAIN : PASS)
                : (sel_valid && sel_last ? IDLE : DRAIN);
   end
   always_ff @(posedge clk156) begin
      if (reset) begin
         state <= IDLE;
         grant_idx <= GW'(N_PORTS - 1);
         beat_cnt <= '0;
         frames_sent <= '0;
         frames_aborted <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && |s_axis_tvalid) grant_idx <= next_idx;
         if (beat) beat_cnt <= (sel_last || abort) ? '0 : beat_cnt + BW'(1);
         frames_sent <= frames_sent + CNT_W'(beat && sel_last);
         frames_aborted <= frames_aborted + CNT_W'(abort);
      end
   end
endmodule
